// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one word request at a time
// over a valid/ready memory port and queues returned instructions with their PCs.
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     ADDR_WIDTH = 10,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    output logic                  REQ_VALID,
    input  logic                  REQ_READY,
    output logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic                  RSP_VALID,
    input  logic [XLEN-1:0]       RSP_DATA,
    output logic                  INST_VALID,
    input  logic                  INST_READY,
    output logic [XLEN-1:0]       INST_DATA,
    output logic [XLEN-1:0]       INST_PC,
    output logic [XLEN-1:0]       INST_PC_PLUS4,
    input  logic                  REDIRECT_VALID,
    input  logic [XLEN-1:0]       REDIRECT_PC,
    output logic                  MISALIGNED
);

    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  req_pc_q;
    logic             misaligned_q;

    logic [XLEN-1:0]  mem_data [FIFO_DEPTH];
    logic [XLEN-1:0]  mem_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_inc;
    logic [CNT_W-1:0] count_q, count_next;

    logic [XLEN-1:0]  head_data_q, head_pc_q, head_pc4_q;

    logic hs, push, pop;

    // A redirect suppresses push and pop: the flush wins over both.
    assign hs         = (state_q == REQ) && REQ_READY;
    assign push       = (state_q == WAIT) && RSP_VALID && !REDIRECT_VALID;
    assign pop        = (count_q != '0) && INST_READY && !REDIRECT_VALID;
    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (REDIRECT_VALID || (count_q < DEPTH_C)) state_d = REQ;
            REQ:  if (hs) state_d = REDIRECT_VALID ? DROP : WAIT;
            WAIT: begin
                if (RSP_VALID)
                    state_d = (REDIRECT_VALID || (count_next < DEPTH_C)) ? REQ : IDLE;
                else if (REDIRECT_VALID)
                    state_d = DROP;
            end
            DROP: if (RSP_VALID) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= REDIRECT_VALID && (REDIRECT_PC[1:0] != 2'b00);
            if (hs)
                req_pc_q <= fetch_pc_q;
            if (REDIRECT_VALID)
                fetch_pc_q <= {REDIRECT_PC[XLEN-1:2], 2'b00};
            else if (hs)
                fetch_pc_q <= fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr_q] <= RSP_DATA;
            mem_pc[wr_ptr_q]   <= req_pc_q;
        end
    end

    // Head registers hold the next entry so outputs move only on pop, push-into-empty or flush.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_data_q <= '0;
            head_pc_q   <= '0;
            head_pc4_q  <= '0;
        end else if (REDIRECT_VALID) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_data_q <= '0;
            head_pc_q   <= '0;
            head_pc4_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_inc;
            count_q <= count_next;
            if (pop && (count_q > CNT_W'(1))) begin
                head_data_q <= mem_data[rd_ptr_inc];
                head_pc_q   <= mem_pc[rd_ptr_inc];
                head_pc4_q  <= mem_pc[rd_ptr_inc] + PC_STEP;
            end else if (push && ((count_q == '0) || pop)) begin
                head_data_q <= RSP_DATA;
                head_pc_q   <= req_pc_q;
                head_pc4_q  <= req_pc_q + PC_STEP;
            end
        end
    end

    assign REQ_VALID     = (state_q == REQ);
    assign REQ_ADDR      = fetch_pc_q[ADDR_WIDTH+1:2];
    assign INST_VALID    = (count_q != '0);
    assign INST_DATA     = head_data_q;
    assign INST_PC       = head_pc_q;
    assign INST_PC_PLUS4 = head_pc4_q;
    assign MISALIGNED    = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: two instances (RESET_PC 0 and 0xFFFFFFFC) with
// behavioural memories; stimulus queues expected instructions/requests, monitors pop them.
module tb_fetch_unit;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, a_req_valid, a_req_ready, a_rsp_valid, a_inst_valid, a_inst_ready;
    logic        a_redir_valid, a_misaligned;
    logic [AW-1:0] a_req_addr;
    logic [31:0] a_rsp_data, a_inst_data, a_inst_pc, a_inst_pc4, a_redir_pc;

    logic        rst_b_n, b_req_valid, b_req_ready, b_rsp_valid, b_inst_valid, b_inst_ready;
    logic        b_redir_valid, b_misaligned;
    logic [AW-1:0] b_req_addr;
    logic [31:0] b_rsp_data, b_inst_data, b_inst_pc, b_inst_pc4, b_redir_pc;

    fetch_unit #(.XLEN(32), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .CLK(clk), .RESET_N(rst_a_n),
        .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready), .REQ_ADDR(a_req_addr),
        .RSP_VALID(a_rsp_valid), .RSP_DATA(a_rsp_data),
        .INST_VALID(a_inst_valid), .INST_READY(a_inst_ready), .INST_DATA(a_inst_data),
        .INST_PC(a_inst_pc), .INST_PC_PLUS4(a_inst_pc4),
        .REDIRECT_VALID(a_redir_valid), .REDIRECT_PC(a_redir_pc), .MISALIGNED(a_misaligned)
    );

    fetch_unit #(.XLEN(32), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK(clk), .RESET_N(rst_b_n),
        .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready), .REQ_ADDR(b_req_addr),
        .RSP_VALID(b_rsp_valid), .RSP_DATA(b_rsp_data),
        .INST_VALID(b_inst_valid), .INST_READY(b_inst_ready), .INST_DATA(b_inst_data),
        .INST_PC(b_inst_pc), .INST_PC_PLUS4(b_inst_pc4),
        .REDIRECT_VALID(b_redir_valid), .REDIRECT_PC(b_redir_pc), .MISALIGNED(b_misaligned)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t          exp_a[$];
    exp_t          exp_b[$];
    logic [AW-1:0] exp_req[$];
    exp_t          ea, eb;
    logic [AW-1:0] er;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop_a = 0;
    int n_pop_b = 0;
    int lat_a   = 1;
    bit dmode   = 1'b0;
    bit req_chk = 1'b0;

    function automatic logic [31:0] mdata(input logic [AW-1:0] a, input bit m);
        return m ? {20'hD0000, 2'b00, a} : 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] start, input int n, input bit m);
        exp_t e;
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(4 * i);
            e.pc = pc;
            e.data = mdata(pc[11:2], m);
            exp_a.push_back(e);
        end
    endtask

    task automatic push_b(input logic [31:0] start, input int n);
        exp_t e;
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(4 * i);
            e.pc = pc;
            e.data = mdata(pc[11:2], 1'b1);
            exp_b.push_back(e);
        end
    endtask

    task automatic push_req(input logic [AW-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_req.push_back(start + AW'(i));
    endtask

    task automatic wait_pops(input int target, input string name);
        int k;
        k = 0;
        while (n_pop_a < target && k < 300) begin
            step();
            k++;
        end
        n_tests++;
        if (n_pop_a < target) begin
            n_fail++;
            $display("FAIL %s timeout: pops %0d expected %0d", name, n_pop_a, target);
        end
    endtask

    // Memory models: A has programmable latency, B answers one cycle after acceptance.
    logic       a_pend;
    int         a_cnt;
    logic [AW-1:0] a_paddr;
    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            a_pend <= 1'b0; a_cnt <= 0; a_paddr <= '0;
            a_rsp_valid <= 1'b0; a_rsp_data <= '0;
        end else begin
            a_rsp_valid <= 1'b0;
            if (a_pend) begin
                if (a_cnt <= 1) begin
                    a_rsp_valid <= 1'b1;
                    a_rsp_data  <= mdata(a_paddr, dmode);
                    a_pend      <= 1'b0;
                end else a_cnt <= a_cnt - 1;
            end
            if (a_req_valid && a_req_ready) begin
                if (lat_a <= 1) begin
                    a_rsp_valid <= 1'b1;
                    a_rsp_data  <= mdata(a_req_addr, dmode);
                end else begin
                    a_pend <= 1'b1; a_cnt <= lat_a - 1; a_paddr <= a_req_addr;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_b_n) begin
        if (!rst_b_n) begin
            b_rsp_valid <= 1'b0; b_rsp_data <= '0;
        end else begin
            b_rsp_valid <= b_req_valid && b_req_ready;
            b_rsp_data  <= mdata(b_req_addr, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (rst_a_n && a_inst_valid && a_inst_ready && !a_redir_valid) begin
            n_pop_a++;
            if (exp_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL inst_a unexpected: got pc %h expected none", a_inst_pc);
            end else begin
                ea = exp_a.pop_front();
                check("inst_a_pc", a_inst_pc, ea.pc);
                check("inst_a_data", a_inst_data, ea.data);
                check("inst_a_pc4", a_inst_pc4, ea.pc + 32'd4);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b_n && b_inst_valid && b_inst_ready) begin
            n_pop_b++;
            if (exp_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL inst_b unexpected: got pc %h expected none", b_inst_pc);
            end else begin
                eb = exp_b.pop_front();
                check("inst_b_pc", b_inst_pc, eb.pc);
                check("inst_b_data", b_inst_data, eb.data);
                check("inst_b_pc4", b_inst_pc4, eb.pc + 32'd4);
            end
        end
    end

    // A handshake under redirect is stale and not part of the expected address stream.
    always @(negedge clk) begin
        if (req_chk && rst_a_n && a_req_valid && a_req_ready && !a_redir_valid) begin
            if (exp_req.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL req_addr unexpected: got %h expected none", a_req_addr);
            end else begin
                er = exp_req.pop_front();
                check("req_addr", 32'(a_req_addr), 32'(er));
            end
        end
    end

    initial begin
        int k;
        int base;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_req_ready = 1'b1; a_inst_ready = 1'b0; a_redir_valid = 1'b0; a_redir_pc = '0;
        b_req_ready = 1'b1; b_inst_ready = 1'b1; b_redir_valid = 1'b0; b_redir_pc = '0;
        #12;
        check("rst_a_req_valid", a_req_valid, 0);
        check("rst_a_inst_valid", a_inst_valid, 0);
        check("rst_a_inst_data", a_inst_data, 0);
        check("rst_a_inst_pc", a_inst_pc, 0);
        check("rst_a_inst_pc4", a_inst_pc4, 0);
        check("rst_a_misaligned", a_misaligned, 0);
        check("rst_a_req_addr", 32'(a_req_addr), 0);
        check("rst_b_req_addr", 32'(b_req_addr), 32'h3FF);

        // Wrap instance: PC 0xFFFFFFFC rolls over to 0, then reset mid-WAIT.
        push_b(32'hFFFF_FFFC, 16);
        step();
        rst_b_n = 1'b1;
        k = 0;
        while (n_pop_b < 3 && k < 100) begin step(); k++; end
        check("wrap_pops", (n_pop_b >= 3), 1);
        k = 0;
        do begin @(negedge clk); k++; end while (!(b_req_valid && b_req_ready) && k < 50);
        check("wrap_hs_seen", (b_req_valid && b_req_ready), 1);
        step();
        #2 rst_b_n = 1'b0;
        #1;
        check("wrap_rst_req_valid", b_req_valid, 0);
        check("wrap_rst_inst_valid", b_inst_valid, 0);
        check("wrap_rst_inst_data", b_inst_data, 0);
        check("wrap_rst_inst_pc", b_inst_pc, 0);
        check("wrap_rst_inst_pc4", b_inst_pc4, 0);
        check("wrap_rst_misaligned", b_misaligned, 0);
        check("wrap_rst_req_addr", 32'(b_req_addr), 32'h3FF);
        exp_b.delete();

        // Decode stalled: exactly four fetches fill the queue, then the FSM idles.
        step();
        push_req('0, 4);
        push_a(32'h0, 4, 1'b0);
        req_chk = 1'b1;
        rst_a_n = 1'b1;
        repeat (20) step();
        check("full_req_count", exp_req.size(), 0);
        check("full_req_valid", a_req_valid, 0);
        check("full_inst_valid", a_inst_valid, 1);
        check("full_inst_pc", a_inst_pc, 32'h0);
        check("full_inst_data", a_inst_data, 32'h13);
        check("full_pops", n_pop_a, 0);

        // Drain in order, fetching resumes at 0x10.
        push_req(AW'(4), 40);
        push_a(32'h10, 40, 1'b0);
        a_inst_ready = 1'b1;
        wait_pops(6, "drain");

        // Redirect to 0x100 while waiting on a 3-cycle response.
        lat_a = 3;
        k = 0;
        do begin @(negedge clk); k++; end while (!(a_req_valid && a_req_ready) && k < 50);
        check("d_hs_seen", (a_req_valid && a_req_ready), 1);
        step();
        dmode = 1'b1;
        a_redir_valid = 1'b1; a_redir_pc = 32'h100;
        exp_a.delete(); exp_req.delete();
        push_req(AW'(32'h40), 40);
        push_a(32'h100, 40, 1'b1);
        step();
        a_redir_valid = 1'b0;
        check("d_drop_req_valid", a_req_valid, 0);
        check("d_misaligned", a_misaligned, 0);
        check("d_flush_inst_valid", a_inst_valid, 0);
        base = n_pop_a;
        wait_pops(base + 3, "after_redirect_wait");

        // Redirect coincident with a request handshake.
        k = 0;
        do begin step(); k++; end while (!a_req_valid && k < 50);
        check("e_req_seen", a_req_valid, 1);
        a_redir_valid = 1'b1; a_redir_pc = 32'h200;
        exp_a.delete(); exp_req.delete();
        push_req(AW'(32'h80), 40);
        push_a(32'h200, 40, 1'b1);
        step();
        a_redir_valid = 1'b0;
        check("e_flush_inst_valid", a_inst_valid, 0);
        base = n_pop_a;
        wait_pops(base + 3, "after_redirect_hs");

        // Redirect coincident with a response and a pop.
        lat_a = 1;
        a_inst_ready = 1'b0;
        k = 0;
        do begin step(); k++; end while (!(a_rsp_valid && a_inst_valid) && k < 50);
        check("f_rsp_pop_seen", (a_rsp_valid && a_inst_valid), 1);
        a_inst_ready = 1'b1;
        a_redir_valid = 1'b1; a_redir_pc = 32'h300;
        exp_a.delete(); exp_req.delete();
        push_req(AW'(32'hC0), 40);
        push_a(32'h300, 40, 1'b1);
        step();
        a_redir_valid = 1'b0;
        check("f_flush_inst_valid", a_inst_valid, 0);
        base = n_pop_a;
        wait_pops(base + 3, "after_redirect_rsp");

        // Misaligned target: one-cycle pulse, fetch from the aligned address.
        step();
        a_redir_valid = 1'b1; a_redir_pc = 32'h102;
        exp_a.delete(); exp_req.delete();
        push_req(AW'(32'h40), 40);
        push_a(32'h100, 40, 1'b1);
        step();
        a_redir_valid = 1'b0;
        check("g_misaligned_hi", a_misaligned, 1);
        step();
        check("g_misaligned_lo", a_misaligned, 0);
        base = n_pop_a;
        wait_pops(base + 3, "after_misaligned");

        req_chk = 1'b0;
        a_inst_ready = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the core. Replaces the single-cycle arrangement of a free-running PC register directly addressing an instruction ROM. Owns the architectural fetch PC and issues word requests over a valid/ready memory interface that tolerates variable latency. Buffers returned instructions, with their PCs, in a FIFO_DEPTH-entry queue feeding decode, and handles branch/jump redirects from execute, including discarding stale in-flight responses.

## Interface
- XLEN, 32, width of PC and instruction data
- ADDR_WIDTH, 10, memory word-address width
- FIFO_DEPTH, 4, instruction queue entries; power of two, ≥2
- RESET_PC, 0, fetch PC after reset; must be 4-byte aligned
- CLK  input  1  clock, rising edge
- RESET_N  input  1  asynchronous, active-low reset
- REQ_VALID  output  1  fetch request valid
- REQ_READY  input  1  memory accepts request
- REQ_ADDR  output  ADDR_WIDTH  word address, equal to fetch PC[ADDR_WIDTH+1:2]
- RSP_VALID  input  1  response data valid; earliest one cycle after acceptance
- RSP_DATA  input  XLEN  instruction word
- INST_VALID  output  1  queue head valid
- INST_READY  input  1  decode consumes head
- INST_DATA  output  XLEN  head instruction
- INST_PC  output  XLEN  PC of head instruction
- INST_PC_PLUS4  output  XLEN  INST_PC+4, modulo 2^XLEN
- REDIRECT_VALID  input  1  taken branch/jump
- REDIRECT_PC  input  XLEN  redirect target
- MISALIGNED  output  1  registered one-cycle pulse: the last redirect had REDIRECT_PC[1:0]≠0

## Operation
- State: fetch PC (XLEN bits), request PC (PC of the outstanding request), FSM, FIFO of {data, pc} with count 0..FIFO_DEPTH.
- At most one request outstanding. Responses are in order.
- FSM states:
  - IDLE: no request. Go to REQ when count < FIFO_DEPTH.
  - REQ: REQ_VALID=1. On REQ_VALID&&REQ_READY: request PC := fetch PC, fetch PC += 4, go to WAIT.
  - WAIT: awaiting a response. On RSP_VALID: push {RSP_DATA, request PC}. Next state is REQ if count after push and pop < FIFO_DEPTH, else IDLE.
  - DROP: awaiting a stale response. On RSP_VALID: discard the data and go to REQ.
- Issue rule: REQ is entered only when a FIFO slot is free. A push therefore never overflows, even with no pop.
- Pop: on INST_VALID&&INST_READY. INST_VALID = (count≠0). Outputs are driven from the head and change only on pop, push-into-empty, flush or reset.
- Simultaneous push and pop: count is unchanged, and both pointers advance modulo FIFO_DEPTH.
- Redirect has priority over every other event in the same cycle:
  - FIFO is flushed (count := 0, pointers reset). Any pop that cycle is ignored.
  - Fetch PC := {REDIRECT_PC[XLEN-1:2], 2'b00}.
  - MISALIGNED := (REDIRECT_PC[1:0]≠0) on the next cycle. Otherwise it is 0.
  - Next state by current state:
    - IDLE → REQ.
    - REQ without handshake → REQ.
    - REQ with handshake → DROP; the accepted request is stale.
    - WAIT with RSP_VALID → REQ; the response is discarded.
    - WAIT without RSP_VALID → DROP.
    - DROP with RSP_VALID → REQ.
    - DROP without RSP_VALID → DROP.
- Arithmetic: all PC additions are XLEN-bit and wrap modulo 2^XLEN. REQ_ADDR also wraps within 2^ADDR_WIDTH words.
- RSP_VALID in IDLE or REQ is a protocol error and is ignored.

## Timing
- Reset (asynchronous, any state, mid-transaction allowed) gives:
  - FSM=IDLE, fetch PC=RESET_PC, count=0, MISALIGNED=0.
  - REQ_VALID=0, INST_VALID=0, INST_DATA=0, INST_PC=0, INST_PC_PLUS4=0.
  - REQ_ADDR reflects RESET_PC.
- The first rising edge with RESET_N high moves IDLE→REQ. REQ_VALID is high in cycle 1.
- With REQ_READY=1 and response latency 1, the steady-state throughput is one instruction per 2 cycles: REQ, then WAIT.
- Response to INST_VALID latency: a response at edge N is visible at the FIFO output after edge N, provided the FIFO was empty.
- Redirect to new request latency: redirect at edge N gives REQ_VALID with the new address in cycle N+1, unless the FSM enters DROP.
- REQ_VALID is held stable with a stable REQ_ADDR until the handshake or a redirect.

## Test plan
- Reset release with REQ_READY=1, 1-cycle memory returning 0x00000013 at every address, INST_READY=1:
  - REQ_ADDR sequence is 0,1,2,…
  - INST_PC sequence is 0,4,8, with INST_PC_PLUS4 = INST_PC+4.
- INST_READY=0, FIFO_DEPTH=4: after 4 responses, INST_VALID=1, FSM stays IDLE and REQ_VALID=0. Raising INST_READY drains PCs 0,4,8,C in order, then fetching resumes at 0x10.
- Redirect to 0x100 in WAIT with the response delayed 3 cycles:
  - FSM goes to DROP and the stale data is never seen on INST_DATA.
  - The next REQ_ADDR is 0x40 and the first INST_PC is 0x100.
- Redirect coincident with a REQ handshake, and separately coincident with RSP_VALID and INST_READY: the FIFO is empty next cycle and only instructions from the target PC appear.
- REDIRECT_PC=0x102: MISALIGNED pulses for exactly 1 cycle and fetch resumes at 0x100.
- RESET_PC=0xFFFFFFFC, XLEN=32: first INST_PC=0xFFFFFFFC with INST_PC_PLUS4=0, and the second INST_PC is 0. Assert RESET_N low while in WAIT: all outputs return to their reset values immediately.
